// File: rtl/ball_link_pkg.sv
// rtl/ball_link_pkg.sv - shared state type and packet layout for the two-board ball link
package ball_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BIT,
        ACK,
        STOP,
        DONE
    } tx_state_t;

    localparam int PKT_BYTES = 7;

    // Byte positions on the wire; indices 2..6 line up with the slave's register map
    localparam int BYTE_ADDR  = 0;
    localparam int BYTE_PTR   = 1;
    localparam int BYTE_Y_HI  = 2;
    localparam int BYTE_Y_LO  = 3;
    localparam int BYTE_VY    = 4;
    localparam int BYTE_GRAV  = 5;
    localparam int BYTE_SPEED = 6;

endpackage

// File: rtl/i2c_quarter_tick.sv
// rtl/i2c_quarter_tick.sv - SCL quarter-period timer, one-cycle tick at terminal count
module i2c_quarter_tick #(
    parameter int CLK_DIV = 63
) (
    input  logic clk_25MHZ,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_25MHZ or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || cnt == TERM) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = !clear && (cnt == TERM);

endmodule

// File: rtl/ball_tx_i2c_master.sv
// rtl/ball_tx_i2c_master.sv - captures ball state and writes it to the peer board over I2C (option: RETRY_ON_NACK_EN)
module ball_tx_i2c_master
    import ball_link_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h42,
    parameter int         CLK_DIV    = 63,
    parameter logic [7:0] REG_PTR    = 8'h00,
    parameter int         MAX_RETRY  = 3
) (
    input  logic       clk_25MHZ,
    input  logic       reset,
    input  logic       ball_send_trigger,
    input  logic [9:0] ball_y,
    input  logic [7:0] ball_vy,
    input  logic [1:0] gravity_counter,
    input  logic       ball_speed_fast,
    output logic       is_i2c_master_done,
    output logic       busy,
    output logic       nack_error,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i
);

    tx_state_t  state, state_n;
    logic [1:0] qtr, qtr_n;
    logic [2:0] bit_idx, bit_idx_n;
    logic [2:0] byte_idx, byte_idx_n;
    logic       nack_seen, nack_seen_n;
    logic       nack_error_n;
    logic       trig_d;
    logic [1:0] sda_sync;
    logic       capture;
    logic       tick;
    logic       last_attempt;
    logic       cur_bit;
    logic [7:0] pkt [PKT_BYTES];

`ifdef RETRY_ON_NACK_EN
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);
    logic [RW-1:0] retry_cnt, retry_n;
    assign last_attempt = (retry_cnt == RETRY_LAST);
`else
    // Retry limit only matters when retries are compiled in
    logic unused_retry_cfg;
    assign unused_retry_cfg = (MAX_RETRY != 0);
    assign last_attempt = 1'b1;
`endif

    i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk_25MHZ (clk_25MHZ),
        .reset     (reset),
        .clear     (state == IDLE || state == DONE),
        .tick      (tick)
    );

    assign cur_bit = pkt[byte_idx][bit_idx];

    always_comb begin
        state_n      = state;
        qtr_n        = qtr;
        bit_idx_n    = bit_idx;
        byte_idx_n   = byte_idx;
        nack_seen_n  = nack_seen;
        nack_error_n = nack_error;
        capture      = 1'b0;
        scl_oe       = 1'b0;
        sda_oe       = 1'b0;
`ifdef RETRY_ON_NACK_EN
        retry_n      = retry_cnt;
`endif
        unique case (state)
            IDLE: begin
                if (ball_send_trigger && !trig_d) begin
                    capture      = 1'b1;
                    state_n      = START;
                    qtr_n        = 2'd0;
                    byte_idx_n   = 3'd0;
                    nack_seen_n  = 1'b0;
                    nack_error_n = 1'b0;
`ifdef RETRY_ON_NACK_EN
                    retry_n      = '0;
`endif
                end
            end
            START: begin
                sda_oe = 1'b1;
                scl_oe = qtr[0];
                if (tick) begin
                    if (qtr == 2'd1) begin
                        state_n   = BIT;
                        qtr_n     = 2'd0;
                        bit_idx_n = 3'd7;
                    end else begin
                        qtr_n = qtr + 2'd1;
                    end
                end
            end
            BIT: begin
                scl_oe = !qtr[1];
                sda_oe = !cur_bit;
                if (tick) begin
                    qtr_n = qtr + 2'd1;
                    if (qtr == 2'd3) begin
                        if (bit_idx == 3'd0) state_n = ACK;
                        else bit_idx_n = bit_idx - 3'd1;
                    end
                end
            end
            ACK: begin
                scl_oe = !qtr[1];
                if (tick) begin
                    qtr_n = qtr + 2'd1;
                    if (qtr == 2'd2) nack_seen_n = sda_sync[1];
                    if (qtr == 2'd3) begin
                        if (nack_seen) begin
                            state_n = STOP;
                            if (last_attempt) nack_error_n = 1'b1;
                        end else if (byte_idx == 3'(PKT_BYTES - 1)) begin
                            state_n = STOP;
                        end else begin
                            state_n    = BIT;
                            byte_idx_n = byte_idx + 3'd1;
                            bit_idx_n  = 3'd7;
                        end
                    end
                end
            end
            STOP: begin
                scl_oe = (qtr == 2'd0);
                sda_oe = (qtr != 2'd2);
                if (tick) begin
                    if (qtr == 2'd2) begin
                        qtr_n   = 2'd0;
                        state_n = DONE;
`ifdef RETRY_ON_NACK_EN
                        if (nack_seen && !last_attempt) begin
                            state_n     = START;
                            retry_n     = retry_cnt + RW'(1);
                            byte_idx_n  = 3'd0;
                            nack_seen_n = 1'b0;
                        end
`endif
                    end else begin
                        qtr_n = qtr + 2'd1;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // trig_d resets high so a trigger held across reset is not seen as a new edge
    always_ff @(posedge clk_25MHZ or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            qtr        <= 2'd0;
            bit_idx    <= 3'd7;
            byte_idx   <= 3'd0;
            nack_seen  <= 1'b0;
            nack_error <= 1'b0;
            trig_d     <= 1'b1;
            sda_sync   <= 2'b11;
`ifdef RETRY_ON_NACK_EN
            retry_cnt  <= '0;
`endif
        end else begin
            state      <= state_n;
            qtr        <= qtr_n;
            bit_idx    <= bit_idx_n;
            byte_idx   <= byte_idx_n;
            nack_seen  <= nack_seen_n;
            nack_error <= nack_error_n;
            trig_d     <= ball_send_trigger;
            sda_sync   <= {sda_sync[0], sda_i};
`ifdef RETRY_ON_NACK_EN
            retry_cnt  <= retry_n;
`endif
        end
    end

    always_ff @(posedge clk_25MHZ) begin
        if (capture) begin
            pkt[BYTE_ADDR]  <= {SLAVE_ADDR, 1'b0};
            pkt[BYTE_PTR]   <= REG_PTR;
            pkt[BYTE_Y_HI]  <= {ball_y[9:8], 6'b0};
            pkt[BYTE_Y_LO]  <= ball_y[7:0];
            pkt[BYTE_VY]    <= ball_vy;
            pkt[BYTE_GRAV]  <= {6'b0, gravity_counter};
            pkt[BYTE_SPEED] <= {7'b0, ball_speed_fast};
        end
    end

    assign is_i2c_master_done = (state == DONE);
    assign busy               = (state != IDLE) && (state != DONE);

endmodule
